bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_adder_if.sv | 24 ++
 rtl/bit_serial_adder.sv | 157 +++++++++++++++
 tb/tb_bit_serial_adder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bit_serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
//   load       parallel-load strobe (master -> slave)
//   input_A    operand A, unsigned 8 bits (master -> slave)
//   input_B    operand B, unsigned 8 bits (master -> slave)
//   sum        8-bit result register (slave -> master)
//   carry_out  final carry, bit 8 of A+B (slave -> master)
// Clock and reset are kept outside the bundle as plain ports.
interface bit_serial_adder_if;
  logic       load;
  logic [7:0] input_A;
  logic [7:0] input_B;
  logic [7:0] sum;
  logic       carry_out;

  modport master (
    output load, input_A, input_B,
    input  sum, carry_out
  );

  modport slave (
    input  load, input_A, input_B,
    output sum, carry_out
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial 8-bit unsigned adder: one full adder plus a carry flop walk
// the operands LSB first, one bit per clock, for 8 clocks after a load.
// The result sits in a shift register that fills from the MSB end, so after
// the 8th shift it holds A+B mod 256, and the carry flop holds bit 8.
//   clk  rising-edge clock
//   rst  synchronous, active-high; clears data, parks the counter at done
//   bus  bit_serial_adder_if.slave (load, input_A, input_B -> sum, carry_out)
// Priority at every edge: rst > load > shift; idle once 8 bits are done.

// Parallel-load / right-shift register. Serial data enters at the MSB.
//   load_val  value captured when load is high
//   shift_en  shift right by one, shift_in entering at bit W-1
module bsa_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)           q <= '0;
    else if (load)     q <= load_val;
    else if (shift_en) q <= {shift_in, q[W-1:1]};
  end
endmodule

// Single flop with synchronous reset, synchronous clear and enable.
//   clr  forces 0 (used to zero the carry-in at load time)
module bsa_dff (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)      q <= 1'b0;
    else if (clr) q <= 1'b0;
    else if (en)  q <= d;
  end
endmodule

// Bit counter. Reset parks it at MAX (idle/done) so nothing shifts until
// the first load; load restarts it at 0 and it counts up to MAX and stops.
//   busy  high while a bit remains to be processed
module bsa_counter #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  output logic [W-1:0] q,
  output logic         busy
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign busy = (q < MAX_V);

  always_ff @(posedge clk) begin
    if (rst)       q <= MAX_V;
    else if (load) q <= '0;
    else if (busy) q <= q + W'(1);
  end
endmodule

// 1-bit full adder.
module bsa_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module bit_serial_adder (
  input  logic                  clk,
  input  logic                  rst,
  bit_serial_adder_if.slave     bus
);
  logic [7:0] sa, sb, ss;
  logic [3:0] n;
  logic       c;
  logic       busy;
  logic       fa_s, fa_c;

  // Operand registers: zeros shift in behind the consumed bits.
  bsa_shift_reg #(.W(8)) u_sa (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.load),
    .load_val (bus.input_A),
    .shift_en (busy),
    .shift_in (1'b0),
    .q        (sa)
  );

  bsa_shift_reg #(.W(8)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.load),
    .load_val (bus.input_B),
    .shift_en (busy),
    .shift_in (1'b0),
    .q        (sb)
  );

  // Sum register: cleared on load, fills from the top so bit 0 of the
  // result lands at sum[0] after exactly 8 shifts.
  bsa_shift_reg #(.W(8)) u_ss (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.load),
    .load_val (8'h00),
    .shift_en (busy),
    .shift_in (fa_s),
    .q        (ss)
  );

  bsa_full_adder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (c),
    .s  (fa_s),
    .co (fa_c)
  );

  // Carry-in of every addition is 0, hence the clear on load.
  bsa_dff u_c (
    .clk (clk),
    .rst (rst),
    .clr (bus.load),
    .en  (busy),
    .d   (fa_c),
    .q   (c)
  );

  bsa_counter #(.W(4), .MAX(8)) u_n (
    .clk  (clk),
    .rst  (rst),
    .load (bus.load),
    .q    (n),
    .busy (busy)
  );

  // Outputs come straight from flops; no input reaches them combinationally.
  assign bus.sum       = ss;
  assign bus.carry_out = c;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Bench for bit_serial_adder. Stimulus schedules expected {carry_out,sum}
// values against an edge count; a separate monitor samples on the falling
// edge and checks every entry due at that edge.
module tb_bit_serial_adder;
  logic clk, rst;
  bit_serial_adder_if bus ();

  bit_serial_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;     // rising edges completed when the check applies
    logic [8:0] exp;   // {carry_out, sum}
    string      tag;
  } chk_t;

  chk_t sbq[$];
  int   ncyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  // Monitor: at each falling edge, ncyc rising edges have occurred.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].t <= ncyc) begin
          n_total++;
          if (sbq[i].t == ncyc &&
              {bus.carry_out, bus.sum} === sbq[i].exp) begin
            n_pass++;
          end else begin
            $display("FAIL %s edge %0d: got c=%0b sum=%0d, want c=%0b sum=%0d",
                     sbq[i].tag, sbq[i].t, bus.carry_out, bus.sum,
                     sbq[i].exp[8], sbq[i].exp[7:0]);
          end
          sbq.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int t, input logic [8:0] exp, input string tag);
    chk_t e;
    e.t = t; e.exp = exp; e.tag = tag;
    sbq.push_back(e);
  endtask

  // Drives one load edge; returns the edge index of that load.
  task automatic do_load(input logic [7:0] a, input logic [7:0] b, output int l);
    l = ncyc + 1;
    push(l, 9'h000, "load_clr");
    bus.load = 1'b1; bus.input_A = a; bus.input_B = b;
    step();
    bus.load = 1'b0;
  endtask

  task automatic add_chk(input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, input int idle, input string tag);
    int l;
    do_load(a, b, l);
    push(l + 8, exp, tag);
    repeat (idle) step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int l;
    logic [7:0] ra, rb;
    rst = 1'b1; bus.load = 1'b0; bus.input_A = 8'h00; bus.input_B = 8'h00;
    step();
    push(ncyc + 1, 9'h000, "reset");
    step();
    rst = 1'b0;
    push(ncyc + 1, 9'h000, "reset_hold");
    step();

    // 3+2, then held for 10+ further cycles
    do_load(8'd3, 8'd2, l);
    for (int k = 8; k <= 19; k++) push(l + k, 9'd5, "add_3_2_stable");
    repeat (20) step();

    add_chk(8'd131, 8'd130, {1'b1, 8'd5},   10, "add_131_130");
    add_chk(8'd255, 8'd255, {1'b1, 8'd254}, 9,  "add_255_255");
    add_chk(8'd251, 8'd150, {1'b1, 8'd145}, 8,  "add_251_150");
    add_chk(8'd131, 8'd0,   {1'b0, 8'd131}, 8,  "add_131_0");
    add_chk(8'd27,  8'd162, {1'b0, 8'd189}, 8,  "add_27_162");

    // load held for 3 edges; inputs scrambled during the shift phase
    for (int k = 1; k <= 3; k++) push(ncyc + k, 9'h000, "hold_load_clr");
    bus.load = 1'b1; bus.input_A = 8'd147; bus.input_B = 8'd250;
    repeat (3) step();
    bus.load = 1'b0;
    l = ncyc;
    push(l + 7,  {1'b1, 8'd26},  "hold_partial7");
    push(l + 8,  {1'b1, 8'd141}, "hold_result");
    push(l + 12, {1'b1, 8'd141}, "hold_result_kept");
    step();
    bus.input_A = 8'h55; bus.input_B = 8'hAA;
    step();
    bus.input_A = 8'hFF; bus.input_B = 8'h0F;
    repeat (10) step();

    // reset after 4 shifts of 255+1: carry out of bit 3 is 1, sum bits 0
    do_load(8'd255, 8'd1, l);
    push(l + 4, {1'b1, 8'd0}, "rst_partial4");
    repeat (4) step();
    for (int k = 5; k <= 14; k++) push(l + k, 9'h000, "rst_midrun");
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();

    // reload mid-run aborts the first addition
    do_load(8'd100, 8'd100, l);
    repeat (3) step();
    add_chk(8'd187, 8'd66, {1'b0, 8'd253}, 10, "reload_187_66");

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      add_chk(ra, rb, {1'b0, ra} + {1'b0, rb}, 8 + int'($urandom_range(0, 4)), "random");
    end

    repeat (3) step();
    if (sbq.size() != 0) begin
      n_total += sbq.size();
      $display("FAIL unchecked_entries: got %0d left, want 0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
